word_byte_serializer: RTL and testbench

Splits a 32-bit word into a stream of bytes, most-significant selected byte first, under a valid/ready handshake on both sides. It is the transmitting end of the byte-assembly path: a 32-bit register that repeatedly shifts the incoming byte into its low end reconstructs the original value from this block's output. It sits between a word-wide register-file or ALU output and any byte-wide consumer such as a memory write port, a bus, or a byte-shifting register.

---
 rtl/word_byte_serializer.sv | 105 ++++++++++
 tb/tb_word_byte_serializer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
// Splits a 32-bit word into 1..4 bytes. The most-significant selected byte
// comes out first. Both sides use a valid/ready handshake. A final-byte
// output handshake can coincide with loading the next word, so
// back-to-back words leave no bubble.
module word_byte_serializer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] I,
  input  logic [1:0]  Size,
  input  logic        InValid,
  output logic        InReady,
  output logic [7:0]  Q,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Last,
  output logic [1:0]  Remaining
);

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic        [DATA_W-1:0]  shift_p0;
  logic        [1:0]         cnt_p0;
  logic                      in_hs;
  logic                      out_hs;
  logic                      last_hs;

  // Moves the top selected byte of w into bits [31:24]. The unselected
  // upper bytes fall off the top, so they are never emitted.
  function automatic logic [DATA_W-1:0] align_word(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        sz
  );
    logic [DATA_W-1:0] r;
    case (sz)
      2'd0:    r = {w[7:0],  24'h000000};
      2'd1:    r = {w[15:0], 16'h0000};
      2'd2:    r = {w[23:0], 8'h00};
      default: r = w;
    endcase
    return r;
  endfunction

  // Handshake qualifiers. InReady depends on OutReady through a
  // combinational path, so a final byte and a new word can both be
  // accepted at the same edge.
  always_comb begin
    out_hs  = OutValid & OutReady;
    last_hs = out_hs & (cnt_p0 == 2'd0);
    InReady = (state == IDLE) | (out_hs & Last);
    in_hs   = InValid & InReady;
  end

  // State register; a reset drops any word in flight.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: load into SEND, or return to IDLE after the final byte
  // if no new word arrives at the same edge.
  always_comb begin
    state_nxt = state;
    if (in_hs)        state_nxt = SEND;
    else if (last_hs) state_nxt = IDLE;
  end

  // ---- stage p0: byte shift register and remaining-byte count ----
  // Load on input handshake, otherwise advance one byte per output handshake.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      shift_p0 <= '0;
      cnt_p0   <= 2'd0;
    end else if (in_hs) begin
      shift_p0 <= align_word(I, Size);
      cnt_p0   <= Size;
    end else if (out_hs && (cnt_p0 != 2'd0)) begin
      shift_p0 <= {shift_p0[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      cnt_p0   <= cnt_p0 - 2'd1;
    end
  end

  // Output decode from registered state; IDLE presents all zeros.
  always_comb begin
    OutValid  = 1'b0;
    Q         = '0;
    Last      = 1'b0;
    Remaining = 2'd0;
    if (state == SEND) begin
      OutValid  = 1'b1;
      Q         = shift_p0[DATA_W-1 -: BYTE_W];
      Last      = (cnt_p0 == 2'd0);
      Remaining = cnt_p0;
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer
// The reference model is a queue of bytes still owed to the downstream
// side. The head is the byte currently presented. Each accepted word
// appends its low (Size+1) bytes, MSB first.
module tb_word_byte_serializer;

  logic        Clock;
  logic        Reset;
  logic [31:0] I;
  logic [1:0]  Size;
  logic        InValid;
  logic        InReady;
  logic [7:0]  Q;
  logic        OutValid;
  logic        OutReady;
  logic        Last;
  logic [1:0]  Remaining;

  int          n_vec;
  int          n_err;
  logic [7:0]  mq[$];      // model: bytes still to be delivered
  logic [7:0]  seen[$];    // bytes the DUT handed over in a directed test
  logic [7:0]  exp_seq[$];

  word_byte_serializer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .I         (I),
    .Size      (Size),
    .InValid   (InValid),
    .InReady   (InReady),
    .Q         (Q),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Last      (Last),
    .Remaining (Remaining)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic cycle(input logic rstn, input logic iv, input logic [31:0] wi,
                       input logic [1:0] sz, input logic ordy);
    int   n;
    logic rdy;
    @(negedge Clock);
    Reset    = rstn;
    InValid  = iv;
    I        = wi;
    Size     = sz;
    OutReady = ordy;
    #1;
    n   = mq.size();
    rdy = (n == 0) || (ordy && n == 1);
    chk("OutValid",  {31'b0, OutValid}, {31'b0, n != 0});
    chk("Q",         {24'b0, Q},        (n != 0) ? {24'b0, mq[0]} : 32'h0);
    chk("Last",      {31'b0, Last},     {31'b0, n == 1});
    chk("Remaining", {30'b0, Remaining}, (n != 0) ? n - 1 : 0);
    chk("InReady",   {31'b0, InReady},  {31'b0, rdy});
    if (OutValid && ordy) seen.push_back(Q);
    @(posedge Clock);
    if (!rstn) begin
      mq.delete();
    end else begin
      if (ordy && n != 0) void'(mq.pop_front());
      if (iv && rdy)
        for (int k = int'(sz); k >= 0; k--) mq.push_back(wi[8*k +: 8]);
    end
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, seen.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size() && k < seen.size(); k++)
      chk(tag, {24'b0, seen[k]}, {24'b0, exp_seq[k]});
    seen.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b0; InValid = 1'b0; I = '0; Size = '0; OutReady = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    // reset state, stated explicitly
    #1;
    chk("rst_InReady",  {31'b0, InReady},  32'h1);
    chk("rst_OutValid", {31'b0, OutValid}, 32'h0);
    chk("rst_Q",        {24'b0, Q},        32'h0);
    idle(1);
    seen.delete();

    // 4-byte word
    cycle(1'b1, 1'b1, 32'hA1B2C3D4, 2'd3, 1'b1);
    idle(6);
    exp_seq = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    check_seq("seq_4byte");

    // 2-byte word: upper bytes ignored
    cycle(1'b1, 1'b1, 32'hDEAD1234, 2'd1, 1'b1);
    idle(4);
    exp_seq = {8'h12, 8'h34};
    check_seq("seq_2byte");

    // backpressure on first byte
    cycle(1'b1, 1'b1, 32'h01020304, 2'd3, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'hFFFFFFFF, 2'd2, 1'b0);
    idle(6);
    exp_seq = {8'h01, 8'h02, 8'h03, 8'h04};
    check_seq("seq_bp");

    // back-to-back words, InValid held high
    cycle(1'b1, 1'b1, 32'h11223344, 2'd3, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 32'h000000AA, 2'd0, 1'b1);
    idle(4);
    exp_seq = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    check_seq("seq_b2b");

    // reset mid-word drops the rest
    cycle(1'b1, 1'b1, 32'hCAFEBABE, 2'd3, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    #1;
    chk("rstmid_OutValid", {31'b0, OutValid}, 32'h0);
    chk("rstmid_InReady",  {31'b0, InReady},  32'h1);
    idle(5);
    exp_seq = {8'hCA};
    check_seq("seq_rstmid");

    // single byte
    cycle(1'b1, 1'b1, 32'hFFFFFF5A, 2'd0, 1'b1);
    idle(3);
    exp_seq = {8'h5A};
    check_seq("seq_1byte");

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic rstn;
      rstn = ($urandom_range(0, 99) != 0);
      cycle(rstn, $urandom_range(0, 2) != 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
